// File: rtl/rv_fetch_decode_exec.sv
// RV32I front pipeline: IF -> ID (decode, regfile read) -> EX (ALU, branch resolve),
// with a sequentially loaded instruction memory and EX-stage redirect/flush.
module rv_fetch_decode_exec #(
   parameter int unsigned IMEM_WORDS = 32,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wen_i,
   input  logic        pc_incr_en_i,
   output logic [31:0] id_instr_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] ex_instr_o,
   output logic [31:0] ex_pc_o,
   output logic [4:0]  ex_rd_o,
   output logic [31:0] ex_result_o,
   output logic        flush_o,
   output logic [31:0] br_target_o
);

   localparam int unsigned AW  = $clog2(IMEM_WORDS);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [6:0] {
      OPC_OPIMM  = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_STORE  = 7'b0100011
   } opcode_e;

   logic [31:0]   r_imem [IMEM_WORDS];
   logic [AW-1:0] r_load_ptr;
   logic [31:0]   r_regs [32];

   logic [31:0] r_pc;
   logic [31:0] r_ifid_instr, r_ifid_pc;
   logic [31:0] r_idex_instr, r_idex_pc, r_idex_rs1, r_idex_rs2, r_idex_imm;
   logic [31:0] r_exwb_instr, r_exwb_pc, r_exwb_result;
   logic [4:0]  r_exwb_rd;

   logic [31:0] w_fetch_instr;
   opcode_e     w_id_op;
   logic [4:0]  w_id_rs1, w_id_rs2;
   logic [31:0] w_id_imm, w_id_rs1_val, w_id_rs2_val;

   opcode_e     w_ex_op;
   logic [2:0]  w_ex_f3;
   logic [31:0] w_alu_a, w_alu_b, w_alu_y;
   logic        w_alu_alt;
   logic        w_br_taken;
   logic        w_ex_wr;
   logic [4:0]  w_ex_rd;
   logic [31:0] w_ex_result;
   logic        w_ex_flush;
   logic [31:0] w_ex_target;

   // Instruction memory: byte-enabled writes at an auto-incrementing pointer, never reset
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < 4; k++) begin
         if (wen_i[k]) r_imem[r_load_ptr][8*k +: 8] <= wdata_i[8*k +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_load_ptr <= '0;
      else if (|wen_i)   r_load_ptr <= r_load_ptr + AW'(1);
   end

   assign w_fetch_instr = r_imem[r_pc[AW+1:2]];

   // ---------------- ID ----------------
   assign w_id_op  = opcode_e'(r_ifid_instr[6:0]);
   assign w_id_rs1 = r_ifid_instr[19:15];
   assign w_id_rs2 = r_ifid_instr[24:20];

   always_comb begin
      w_id_imm = '0;
      case (w_id_op)
         OPC_OPIMM, OPC_JALR: w_id_imm = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:20]};
         OPC_STORE:  w_id_imm = {{20{r_ifid_instr[31]}}, r_ifid_instr[31:25], r_ifid_instr[11:7]};
         OPC_BRANCH: w_id_imm = {{19{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[7],
                                 r_ifid_instr[30:25], r_ifid_instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC: w_id_imm = {r_ifid_instr[31:12], 12'b0};
         OPC_JAL:    w_id_imm = {{11{r_ifid_instr[31]}}, r_ifid_instr[31], r_ifid_instr[19:12],
                                 r_ifid_instr[20], r_ifid_instr[30:21], 1'b0};
         default:    w_id_imm = '0;
      endcase
   end

   // Write-through: the value EX commits on this edge is visible to the ID read
   assign w_id_rs1_val = (w_id_rs1 == 5'd0) ? '0 :
                         (w_ex_wr && (w_ex_rd == w_id_rs1)) ? w_ex_result : r_regs[w_id_rs1];
   assign w_id_rs2_val = (w_id_rs2 == 5'd0) ? '0 :
                         (w_ex_wr && (w_ex_rd == w_id_rs2)) ? w_ex_result : r_regs[w_id_rs2];

   // ---------------- EX ----------------
   assign w_ex_op   = opcode_e'(r_idex_instr[6:0]);
   assign w_ex_f3   = r_idex_instr[14:12];
   assign w_alu_a   = r_idex_rs1;
   assign w_alu_b   = (w_ex_op == OPC_OP) ? r_idex_rs2 : r_idex_imm;
   assign w_alu_alt = r_idex_instr[30] && ((w_ex_op == OPC_OP) || (w_ex_f3 == 3'b101));

   always_comb begin
      w_alu_y = '0;
      case (w_ex_f3)
         3'b000: w_alu_y = w_alu_alt ? (w_alu_a - w_alu_b) : (w_alu_a + w_alu_b);
         3'b001: w_alu_y = w_alu_a << w_alu_b[4:0];
         3'b010: w_alu_y = {31'b0, $signed(w_alu_a) < $signed(w_alu_b)};
         3'b011: w_alu_y = {31'b0, w_alu_a < w_alu_b};
         3'b100: w_alu_y = w_alu_a ^ w_alu_b;
         3'b101: w_alu_y = w_alu_alt ? 32'($signed(w_alu_a) >>> w_alu_b[4:0])
                                     : (w_alu_a >> w_alu_b[4:0]);
         3'b110: w_alu_y = w_alu_a | w_alu_b;
         default: w_alu_y = w_alu_a & w_alu_b;
      endcase
   end

   always_comb begin
      w_br_taken = 1'b0;
      case (w_ex_f3)
         3'b000: w_br_taken = (r_idex_rs1 == r_idex_rs2);
         3'b001: w_br_taken = (r_idex_rs1 != r_idex_rs2);
         3'b100: w_br_taken = ($signed(r_idex_rs1) <  $signed(r_idex_rs2));
         3'b101: w_br_taken = ($signed(r_idex_rs1) >= $signed(r_idex_rs2));
         3'b110: w_br_taken = (r_idex_rs1 <  r_idex_rs2);
         3'b111: w_br_taken = (r_idex_rs1 >= r_idex_rs2);
         default: w_br_taken = 1'b0;
      endcase
   end

   always_comb begin
      logic        v_writes;
      logic [31:0] v_value;
      v_writes    = 1'b0;
      v_value     = '0;
      w_ex_flush  = 1'b0;
      w_ex_target = '0;
      case (w_ex_op)
         OPC_OPIMM, OPC_OP: begin v_writes = 1'b1; v_value = w_alu_y; end
         OPC_LUI:    begin v_writes = 1'b1; v_value = r_idex_imm; end
         OPC_AUIPC:  begin v_writes = 1'b1; v_value = r_idex_pc + r_idex_imm; end
         OPC_JAL: begin
            v_writes    = 1'b1;
            v_value     = r_idex_pc + 32'd4;
            w_ex_flush  = 1'b1;
            w_ex_target = r_idex_pc + r_idex_imm;
         end
         OPC_JALR: begin
            v_writes    = 1'b1;
            v_value     = r_idex_pc + 32'd4;
            w_ex_flush  = 1'b1;
            w_ex_target = (r_idex_rs1 + r_idex_imm) & ~32'd1;
         end
         OPC_BRANCH: begin
            w_ex_flush  = w_br_taken;
            w_ex_target = r_idex_pc + r_idex_imm;
         end
         default: v_writes = 1'b0;
      endcase
      w_ex_wr     = v_writes && (r_idex_instr[11:7] != 5'd0);
      w_ex_rd     = w_ex_wr ? r_idex_instr[11:7] : 5'd0;
      w_ex_result = w_ex_wr ? v_value : '0;
   end

   // ---------------- pipeline registers and regfile ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc          <= RESET_PC;
         r_ifid_instr  <= NOP;
         r_ifid_pc     <= '0;
         r_idex_instr  <= NOP;
         r_idex_pc     <= '0;
         r_idex_rs1    <= '0;
         r_idex_rs2    <= '0;
         r_idex_imm    <= '0;
         r_exwb_instr  <= NOP;
         r_exwb_pc     <= '0;
         r_exwb_rd     <= '0;
         r_exwb_result <= '0;
         for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (pc_incr_en_i) begin
         if (w_ex_flush) begin
            r_pc         <= w_ex_target;
            r_ifid_instr <= NOP;
            r_ifid_pc    <= '0;
            r_idex_instr <= NOP;
            r_idex_pc    <= '0;
            r_idex_rs1   <= '0;
            r_idex_rs2   <= '0;
            r_idex_imm   <= '0;
         end else begin
            r_pc         <= r_pc + 32'd4;
            r_ifid_instr <= w_fetch_instr;
            r_ifid_pc    <= r_pc;
            r_idex_instr <= r_ifid_instr;
            r_idex_pc    <= r_ifid_pc;
            r_idex_rs1   <= w_id_rs1_val;
            r_idex_rs2   <= w_id_rs2_val;
            r_idex_imm   <= w_id_imm;
         end
         r_exwb_instr  <= r_idex_instr;
         r_exwb_pc     <= r_idex_pc;
         r_exwb_rd     <= w_ex_rd;
         r_exwb_result <= w_ex_result;
         if (w_ex_wr) r_regs[w_ex_rd] <= w_ex_result;
      end
   end

   assign id_instr_o  = r_idex_instr;
   assign id_pc_o     = r_idex_pc;
   assign ex_instr_o  = r_exwb_instr;
   assign ex_pc_o     = r_exwb_pc;
   assign ex_rd_o     = r_exwb_rd;
   assign ex_result_o = r_exwb_result;
   assign flush_o     = w_ex_flush;
   assign br_target_o = w_ex_target;

endmodule

// File: tb/tb_rv_fetch_decode_exec.sv
// Directed bench for rv_fetch_decode_exec: hand-encoded RV32I programs with
// hand-computed pipeline outputs, checked by immediate assertions.
module tb_rv_fetch_decode_exec;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wdata_i;
   logic [3:0]  wen_i;
   logic        pc_incr_en_i;
   logic [31:0] id_instr_o, id_pc_o, ex_instr_o, ex_pc_o, ex_result_o, br_target_o;
   logic [4:0]  ex_rd_o;
   logic        flush_o;

   int n_vec  = 0;
   int n_fail = 0;
   logic [31:0] prog [32];

   rv_fetch_decode_exec #(.IMEM_WORDS(32), .RESET_PC(32'h0)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .wdata_i      (wdata_i),
      .wen_i        (wen_i),
      .pc_incr_en_i (pc_incr_en_i),
      .id_instr_o   (id_instr_o),
      .id_pc_o      (id_pc_o),
      .ex_instr_o   (ex_instr_o),
      .ex_pc_o      (ex_pc_o),
      .ex_rd_o      (ex_rd_o),
      .ex_result_o  (ex_result_o),
      .flush_o      (flush_o),
      .br_target_o  (br_target_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      pc_incr_en_i = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      pc_incr_en_i = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0; pc_incr_en_i = 1'b0; wen_i = 4'h0; wdata_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_id_instr", id_instr_o, NOP);
      chk("rst_ex_instr", ex_instr_o, NOP);
      chk("rst_ex_result", ex_result_o, 32'd0);
      chk("rst_ex_rd", {27'd0, ex_rd_o}, 32'd0);
      chk("rst_flush", {31'd0, flush_o}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_id_pc", id_pc_o, 32'd0);
      chk("rel_ex_pc", ex_pc_o, 32'd0);
      chk("rel_ex_instr", ex_instr_o, NOP);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 32; i++) prog[i] = NOP;
   endtask

   task automatic load_prog();
      for (int i = 0; i < 32; i++) begin
         wdata_i = prog[i];
         wen_i   = 4'hF;
         @(posedge clk);
         #1;
      end
      wen_i = 4'h0;
   endtask

   initial begin
      // 1. reset
      do_reset();

      // 2. single op; word 0 finished by a half-word write after the pointer wraps
      clear_prog();
      prog[0] = 32'hAAAA_0293;
      load_prog();
      wdata_i = 32'h00E0_5555; wen_i = 4'b1100;
      @(posedge clk); #1;
      wen_i = 4'h0;
      step(3);
      chk("single_instr", ex_instr_o, 32'h00E0_0293);
      chk("single_rd", {27'd0, ex_rd_o}, 32'd5);
      chk("single_result", ex_result_o, 32'd14);
      chk("single_pc", ex_pc_o, 32'd0);
      step(1);
      chk("single_next_pc", ex_pc_o, 32'd4);

      // 3. back-to-back dependency
      do_reset();
      clear_prog();
      prog[0] = 32'h0050_0093;   // addi x1,x0,5
      prog[1] = 32'h0030_8113;   // addi x2,x1,3
      load_prog();
      step(3);
      chk("dep_first", ex_result_o, 32'd5);
      step(1);
      chk("dep_instr", ex_instr_o, 32'h0030_8113);
      chk("dep_result", ex_result_o, 32'd8);
      chk("dep_rd", {27'd0, ex_rd_o}, 32'd2);
      chk("dep_pc", ex_pc_o, 32'd4);

      // 4. taken branch
      do_reset();
      clear_prog();
      prog[0] = 32'h0000_0463;   // beq x0,x0,+8
      prog[1] = 32'h0010_0193;   // addi x3,x0,1 (shadow)
      prog[2] = 32'h0070_0213;   // addi x4,x0,7
      load_prog();
      step(2);
      chk("br_id_instr", id_instr_o, 32'h0000_0463);
      chk("br_flush", {31'd0, flush_o}, 32'd1);
      chk("br_target", br_target_o, 32'd8);
      step(1);
      chk("br_ex_instr", ex_instr_o, 32'h0000_0463);
      chk("br_ex_rd", {27'd0, ex_rd_o}, 32'd0);
      chk("br_flush_clear", {31'd0, flush_o}, 32'd0);
      step(1);
      chk("br_bubble1", ex_instr_o, NOP);
      step(1);
      chk("br_bubble2", ex_instr_o, NOP);
      step(1);
      chk("br_tgt_instr", ex_instr_o, 32'h0070_0213);
      chk("br_tgt_pc", ex_pc_o, 32'd8);
      chk("br_tgt_result", ex_result_o, 32'd7);

      // 5. compare / logic, then a not-taken bne
      do_reset();
      clear_prog();
      prog[0] = 32'h0020_0113;   // addi x2,x0,2
      prog[1] = 32'h0051_2113;   // slti x2,x2,5
      prog[2] = 32'h0051_6093;   // ori  x1,x2,5
      prog[3] = 32'h0051_4093;   // xori x1,x2,5
      prog[4] = 32'h0000_1463;   // bne x0,x0,+8
      load_prog();
      step(4);
      chk("slti", ex_result_o, 32'd1);
      step(1);
      chk("ori", ex_result_o, 32'd5);
      step(1);
      chk("xori", ex_result_o, 32'd4);
      chk("bne_no_flush", {31'd0, flush_o}, 32'd0);
      step(1);
      chk("bne_ex_instr", ex_instr_o, 32'h0000_1463);
      step(1);
      chk("bne_fallthru_pc", ex_pc_o, 32'd20);

      // 6. shifts, sub, signed vs unsigned compare
      do_reset();
      clear_prog();
      prog[0] = 32'h8000_02B7;   // lui  x5,0x80000
      prog[1] = 32'h4042_D313;   // srai x6,x5,4
      prog[2] = 32'h0042_D393;   // srli x7,x5,4
      prog[3] = 32'h4073_0433;   // sub  x8,x6,x7
      prog[4] = 32'h0063_B4B3;   // sltu x9,x7,x6
      prog[5] = 32'h0063_A533;   // slt  x10,x7,x6
      load_prog();
      step(3);
      chk("lui", ex_result_o, 32'h8000_0000);
      step(1);
      chk("srai", ex_result_o, 32'hF800_0000);
      step(1);
      chk("srli", ex_result_o, 32'h0800_0000);
      step(1);
      chk("sub", ex_result_o, 32'hF000_0000);
      step(1);
      chk("sltu", ex_result_o, 32'd1);
      step(1);
      chk("slt", ex_result_o, 32'd0);
      chk("slt_rd", {27'd0, ex_rd_o}, 32'd10);

      // 7. jal / jalr
      do_reset();
      clear_prog();
      prog[0] = 32'h00C0_00EF;   // jal  x1,+12
      prog[2] = 32'h0011_0193;   // addi x3,x2,1
      prog[3] = 32'h0050_8167;   // jalr x2,5(x1)
      load_prog();
      step(2);
      chk("jal_flush", {31'd0, flush_o}, 32'd1);
      chk("jal_target", br_target_o, 32'd12);
      step(1);
      chk("jal_rd", {27'd0, ex_rd_o}, 32'd1);
      chk("jal_link", ex_result_o, 32'd4);
      step(2);
      chk("jalr_id_pc", id_pc_o, 32'd12);
      chk("jalr_flush", {31'd0, flush_o}, 32'd1);
      chk("jalr_target", br_target_o, 32'd8);
      step(1);
      chk("jalr_link", ex_result_o, 32'd16);
      step(3);
      chk("jalr_tgt_instr", ex_instr_o, 32'h0011_0193);
      chk("jalr_tgt_pc", ex_pc_o, 32'd8);
      chk("jalr_tgt_result", ex_result_o, 32'd17);

      // 8. stall mid-stream
      do_reset();
      clear_prog();
      prog[0] = 32'h0010_0093;   // addi x1,x0,1
      for (int i = 1; i < 6; i++) prog[i] = 32'h0010_8093;   // addi x1,x1,1
      load_prog();
      step(4);
      chk("pre_stall_result", ex_result_o, 32'd2);
      pc_incr_en_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("stall_ex_result", ex_result_o, 32'd2);
         chk("stall_ex_pc", ex_pc_o, 32'd4);
         chk("stall_id_pc", id_pc_o, 32'd8);
         chk("stall_id_instr", id_instr_o, 32'h0010_8093);
      end
      step(1);
      chk("resume1_result", ex_result_o, 32'd3);
      chk("resume1_pc", ex_pc_o, 32'd8);
      step(1);
      chk("resume2_result", ex_result_o, 32'd4);
      step(1);
      chk("resume3_result", ex_result_o, 32'd5);
      chk("resume3_pc", ex_pc_o, 32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
